// File: rtl/mem_cache_pkg.sv
// Purpose: shared geometry, FSM state type and address view for mem_cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_cache_pkg;

  localparam int TAG_W  = 6;
  localparam int IDX_W  = 6;
  localparam int OFF_W  = 3;
  localparam int WAYS   = 2;
  localparam int WAY_W  = 1;
  localparam int SETS   = 1 << IDX_W;
  localparam int WORDS  = 1 << OFF_W;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic {IDLE, FILL} state_t;

  // Byte address split: tag | index | word | byte.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] word;
    logic             byte_sel;
  } addr_t;

  function automatic addr_t split_addr(input logic [ADDR_W-1:0] a);
    return addr_t'(a);
  endfunction

endpackage

// File: rtl/cache_fill_fsm.sv
// Purpose: line-fill sequencer; issues 8 word requests and counts 8 returned words.
// Latency: requests start the cycle after start_i; finish pulses with the 8th valid word.
// Backpressure: none; memory data may arrive with any delay, in request order.
// Ports: start_i/miss_*/victim_way_i latch a miss; mem_data_vld_i counts fill words;
//        fill_* drive the memory request and the data/tag array write port.
module cache_fill_fsm
  import mem_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [TAG_W-1:0]     miss_tag_i,
  input  logic [IDX_W-1:0]     miss_idx_i,
  input  logic [WAY_W-1:0]     victim_way_i,
  input  logic                 mem_data_vld_i,
  output logic                 fill_busy_o,
  output logic                 fill_mem_rd_o,
  output logic [ADDR_W-1:0]    fill_mem_addr_o,
  output logic                 fill_we_o,
  output logic [TAG_W-1:0]     fill_tag_o,
  output logic [IDX_W-1:0]     fill_idx_o,
  output logic [WAY_W-1:0]     fill_way_o,
  output logic [OFF_W-1:0]     fill_word_o,
  output logic                 write_tag_array_o,
  output logic                 cache_finish_o
);

  state_t           state_q, state_d;
  // One extra bit: the MSB marks "all 8 requests issued".
  logic [OFF_W:0]   req_cnt_q, req_cnt_d;
  logic [OFF_W-1:0] data_cnt_q, data_cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic             last_word;

  assign last_word = (state_q == FILL) && mem_data_vld_i &&
                     (data_cnt_q == OFF_W'(WORDS - 1));

  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    data_cnt_d = data_cnt_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    way_d      = way_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = FILL;
          req_cnt_d  = '0;
          data_cnt_d = '0;
          tag_d      = miss_tag_i;
          idx_d      = miss_idx_i;
          way_d      = victim_way_i;
        end
      end
      FILL: begin
        if (!req_cnt_q[OFF_W]) req_cnt_d = req_cnt_q + 1'b1;
        if (mem_data_vld_i) begin
          data_cnt_d = data_cnt_q + 1'b1;
          if (last_word) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_cnt_q  <= '0;
      data_cnt_q <= '0;
      tag_q      <= '0;
      idx_q      <= '0;
      way_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      data_cnt_q <= data_cnt_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      way_q      <= way_d;
    end
  end

  assign fill_busy_o       = (state_q == FILL);
  assign fill_mem_rd_o     = (state_q == FILL) && !req_cnt_q[OFF_W];
  assign fill_mem_addr_o   = fill_mem_rd_o ? {tag_q, idx_q, req_cnt_q[OFF_W-1:0], 1'b0} : '0;
  assign fill_we_o         = (state_q == FILL) && mem_data_vld_i;
  assign fill_tag_o        = tag_q;
  assign fill_idx_o        = idx_q;
  assign fill_way_o        = way_q;
  assign fill_word_o       = data_cnt_q;
  assign write_tag_array_o = last_word;
  assign cache_finish_o    = last_word;

endmodule

// File: rtl/mem_cache.sv
// Purpose: 2-way set-associative write-through, no-write-allocate cache, 8-word lines.
// Latency: hits return data combinationally; a read miss stalls ~9+ cycles for the line fill.
// Backpressure: CacheBusy stalls the pipeline on a read miss and throughout the fill.
// Ports: pipe_* request side; MemDataValid/mem_read_data fill data in;
//        cache_MemRead/cache_MemWrite/cache_mem_addr to memory; CacheHit/CacheBusy/CacheFinish status.
module mem_cache
  import mem_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_MemRead,
  input  logic [15:0]       pipe_read_addr,
  input  logic              pipe_MemWrite,
  input  logic [15:0]       pipe_mem_write_addr,
  input  logic [15:0]       pipe_mem_write_data,
  input  logic              MemDataValid,
  input  logic [15:0]       mem_read_data,
  output logic              cache_MemWrite,
  output logic              cache_MemRead,
  output logic [15:0]       cache_mem_addr,
  output logic [15:0]       cache_data_out,
  output logic              CacheFinish,
  output logic              CacheHit,
  output logic              CacheBusy
);

  // Data and tag arrays are not reset; validity alone gates hits.
  logic [DATA_W-1:0] data_q [SETS][WAYS][WORDS];
  logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
  // Per set: index of the least-recently-used way (next victim).
  logic [SETS-1:0]   lru_q, lru_d;

  addr_t ra, wa;
  logic  rd_hit, wr_hit;
  logic [WAY_W-1:0] rd_way, wr_way, victim_way;
  logic  idle, rd_req, wr_req, rd_hit_v, rd_miss, wr_go, wr_upd;

  logic              fill_busy, fill_mem_rd, fill_we, write_tag_array;
  logic [ADDR_W-1:0] fill_mem_addr;
  logic [TAG_W-1:0]  fill_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [WAY_W-1:0]  fill_way;
  logic [OFF_W-1:0]  fill_word;

  // Byte-select bits are irrelevant for a 16-bit word cache.
  logic unused_byte_sel;
  assign unused_byte_sel = ra.byte_sel ^ wa.byte_sel;

  assign ra = split_addr(pipe_read_addr);
  assign wa = split_addr(pipe_mem_write_addr);

  always_comb begin
    rd_hit = 1'b0;
    rd_way = '0;
    wr_hit = 1'b0;
    wr_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[ra.idx][w] && (tag_q[ra.idx][w] == ra.tag)) begin
        rd_hit = 1'b1;
        rd_way = w[WAY_W-1:0];
      end
      if (valid_q[wa.idx][w] && (tag_q[wa.idx][w] == wa.tag)) begin
        wr_hit = 1'b1;
        wr_way = w[WAY_W-1:0];
      end
    end
  end

  // Prefer an invalid way (way0 first) before evicting the LRU way.
  always_comb begin
    if (!valid_q[ra.idx][0])      victim_way = 1'b0;
    else if (!valid_q[ra.idx][1]) victim_way = 1'b1;
    else                          victim_way = lru_q[ra.idx];
  end

  assign idle     = !fill_busy;
  assign rd_req   = idle && pipe_MemRead;
  assign wr_req   = idle && pipe_MemWrite;
  assign rd_hit_v = rd_req && rd_hit;
  assign rd_miss  = rd_req && !rd_hit;
  // A read miss takes priority; the pipeline stalls and re-presents the write.
  assign wr_go    = wr_req && !rd_miss;
  assign wr_upd   = wr_go && wr_hit;

  always_comb begin
    lru_d   = lru_q;
    valid_d = valid_q;
    if (rd_hit_v) lru_d[ra.idx] = ~rd_way;
    if (wr_upd)   lru_d[wa.idx] = ~wr_way;
    // Victim is invalidated up front so a partially filled line never hits.
    if (rd_miss)  valid_d[ra.idx][victim_way] = 1'b0;
    if (write_tag_array) begin
      valid_d[fill_idx][fill_way] = 1'b1;
      lru_d[fill_idx]             = ~fill_way;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      valid_q <= valid_d;
      lru_q   <= lru_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_upd)          data_q[wa.idx][wr_way][wa.word]      <= pipe_mem_write_data;
    if (fill_we)         data_q[fill_idx][fill_way][fill_word] <= mem_read_data;
    if (write_tag_array) tag_q[fill_idx][fill_way]             <= fill_tag;
  end

  cache_fill_fsm u_fill (
    .clk               (clk),
    .rst               (rst),
    .start_i           (rd_miss),
    .miss_tag_i        (ra.tag),
    .miss_idx_i        (ra.idx),
    .victim_way_i      (victim_way),
    .mem_data_vld_i    (MemDataValid),
    .fill_busy_o       (fill_busy),
    .fill_mem_rd_o     (fill_mem_rd),
    .fill_mem_addr_o   (fill_mem_addr),
    .fill_we_o         (fill_we),
    .fill_tag_o        (fill_tag),
    .fill_idx_o        (fill_idx),
    .fill_way_o        (fill_way),
    .fill_word_o       (fill_word),
    .write_tag_array_o (write_tag_array),
    .cache_finish_o    (CacheFinish)
  );

  assign CacheHit       = rd_req ? rd_hit : (wr_req && wr_hit);
  assign CacheBusy      = rd_miss || fill_busy;
  assign cache_data_out = rd_hit_v ? data_q[ra.idx][rd_way][ra.word] : '0;
  assign cache_MemRead  = fill_mem_rd;
  assign cache_MemWrite = wr_go;
  assign cache_mem_addr = fill_mem_rd ? fill_mem_addr :
                          wr_go       ? pipe_mem_write_addr : '0;

endmodule

// File: tb/tb_mem_cache.sv
// Purpose: directed self-checking bench for mem_cache.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 2ns after it.
// Backpressure: fills return data in the same cycle as each request.
module tb_mem_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_MemRead;
  logic [15:0] pipe_read_addr;
  logic        pipe_MemWrite;
  logic [15:0] pipe_mem_write_addr;
  logic [15:0] pipe_mem_write_data;
  logic        MemDataValid;
  logic [15:0] mem_read_data;
  logic        cache_MemWrite;
  logic        cache_MemRead;
  logic [15:0] cache_mem_addr;
  logic [15:0] cache_data_out;
  logic        CacheFinish;
  logic        CacheHit;
  logic        CacheBusy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_cache dut (
    .clk                 (clk),
    .rst                 (rst),
    .pipe_MemRead        (pipe_MemRead),
    .pipe_read_addr      (pipe_read_addr),
    .pipe_MemWrite       (pipe_MemWrite),
    .pipe_mem_write_addr (pipe_mem_write_addr),
    .pipe_mem_write_data (pipe_mem_write_data),
    .MemDataValid        (MemDataValid),
    .mem_read_data       (mem_read_data),
    .cache_MemWrite      (cache_MemWrite),
    .cache_MemRead       (cache_MemRead),
    .cache_mem_addr      (cache_mem_addr),
    .cache_data_out      (cache_data_out),
    .CacheFinish         (CacheFinish),
    .CacheHit            (CacheHit),
    .CacheBusy           (CacheBusy)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_MemRead        = 1'b0;
    pipe_read_addr      = '0;
    pipe_MemWrite       = 1'b0;
    pipe_mem_write_addr = '0;
    pipe_mem_write_data = '0;
    MemDataValid        = 1'b0;
    mem_read_data       = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_hit"},  16'(CacheHit), 16'd0);
    chk({tag, "_busy"}, 16'(CacheBusy), 16'd0);
    chk({tag, "_mrd"},  16'(cache_MemRead), 16'd0);
    chk({tag, "_mwr"},  16'(cache_MemWrite), 16'd0);
    chk({tag, "_addr"}, cache_mem_addr, 16'h0000);
    chk({tag, "_dout"}, cache_data_out, 16'h0000);
    chk({tag, "_fin"},  16'(CacheFinish), 16'd0);
  endtask

  // Read miss then an 8-word fill; word k of the line returns dbase+k.
  task automatic fill_line(input logic [15:0] addr, input logic [15:0] dbase);
    logic [15:0] exp_addr;
    idle_inputs();
    pipe_MemRead   = 1'b1;
    pipe_read_addr = addr;
    #1;
    chk("miss_busy", 16'(CacheBusy), 16'd1);
    chk("miss_hit",  16'(CacheHit), 16'd0);
    chk("miss_mrd",  16'(cache_MemRead), 16'd0);
    tick();
    for (int k = 0; k < 8; k++) begin
      MemDataValid  = 1'b1;
      mem_read_data = dbase + 16'(k);
      #1;
      exp_addr = {addr[15:4], 4'h0} + 16'(2 * k);
      chk("fill_mrd",  16'(cache_MemRead), 16'd1);
      chk("fill_addr", cache_mem_addr, exp_addr);
      chk("fill_busy", 16'(CacheBusy), 16'd1);
      chk("fill_fin",  16'(CacheFinish), (k == 7) ? 16'd1 : 16'd0);
      tick();
    end
    MemDataValid  = 1'b0;
    mem_read_data = '0;
  endtask

  task automatic read_hit(input string tag, input logic [15:0] addr, input logic [15:0] exp_data);
    idle_inputs();
    pipe_MemRead   = 1'b1;
    pipe_read_addr = addr;
    #1;
    chk({tag, "_hit"},  16'(CacheHit), 16'd1);
    chk({tag, "_dout"}, cache_data_out, exp_data);
    chk({tag, "_busy"}, 16'(CacheBusy), 16'd0);
    chk({tag, "_mrd"},  16'(cache_MemRead), 16'd0);
    chk({tag, "_addr"}, cache_mem_addr, 16'h0000);
    chk({tag, "_fin"},  16'(CacheFinish), 16'd0);
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_quiet("reset");

    // Cold miss on 0x0004, line 0x0000 gets data 1..8 (way0).
    fill_line(16'h0004, 16'd1);
    read_hit("rd0004", 16'h0004, 16'd3);
    read_hit("rd0008", 16'h0008, 16'd5);
    read_hit("rd000A", 16'h000A, 16'd6);

    // Same set, tag 1 -> invalid way1; then tag 2 evicts LRU way0.
    fill_line(16'h0400, 16'h0011);
    read_hit("rd0400", 16'h0400, 16'h0011);
    fill_line(16'h0800, 16'h0021);
    read_hit("rd0800", 16'h0800, 16'h0021);
    read_hit("rd040E", 16'h040E, 16'h0018);
    // 0x0000 line was evicted; its refill replaces LRU way (tag 2).
    fill_line(16'h0004, 16'd1);
    read_hit("refill0004", 16'h0004, 16'd3);
    read_hit("still0400", 16'h0402, 16'h0012);

    // Write hit: write-through and array update.
    idle_inputs();
    pipe_MemWrite       = 1'b1;
    pipe_mem_write_addr = 16'h0008;
    pipe_mem_write_data = 16'hBEEF;
    #1;
    chk("wr_hit",  16'(CacheHit), 16'd1);
    chk("wr_mwr",  16'(cache_MemWrite), 16'd1);
    chk("wr_addr", cache_mem_addr, 16'h0008);
    chk("wr_busy", 16'(CacheBusy), 16'd0);
    tick();
    read_hit("rdBEEF", 16'h0008, 16'hBEEF);

    // Read hit and write hit in the same cycle.
    idle_inputs();
    pipe_MemRead        = 1'b1;
    pipe_read_addr      = 16'h0004;
    pipe_MemWrite       = 1'b1;
    pipe_mem_write_addr = 16'h000C;
    pipe_mem_write_data = 16'h1234;
    #1;
    chk("rw_hit",  16'(CacheHit), 16'd1);
    chk("rw_dout", cache_data_out, 16'd3);
    chk("rw_mwr",  16'(cache_MemWrite), 16'd1);
    chk("rw_addr", cache_mem_addr, 16'h000C);
    chk("rw_busy", 16'(CacheBusy), 16'd0);
    tick();
    read_hit("rd000C", 16'h000C, 16'h1234);

    // Write miss: no allocation, no stall, no fill.
    idle_inputs();
    pipe_MemWrite       = 1'b1;
    pipe_mem_write_addr = 16'h2000;
    pipe_mem_write_data = 16'h0F0F;
    #1;
    chk("wm_hit",  16'(CacheHit), 16'd0);
    chk("wm_mwr",  16'(cache_MemWrite), 16'd1);
    chk("wm_addr", cache_mem_addr, 16'h2000);
    chk("wm_busy", 16'(CacheBusy), 16'd0);
    chk("wm_mrd",  16'(cache_MemRead), 16'd0);
    tick();
    idle_inputs();
    #1;
    chk_quiet("after_wm");
    tick();

    // Read miss with a simultaneous write: the read wins.
    pipe_MemRead        = 1'b1;
    pipe_read_addr      = 16'h3000;
    pipe_MemWrite       = 1'b1;
    pipe_mem_write_addr = 16'h0002;
    pipe_mem_write_data = 16'h5555;
    #1;
    chk("rmw_busy", 16'(CacheBusy), 16'd1);
    chk("rmw_hit",  16'(CacheHit), 16'd0);
    chk("rmw_mwr",  16'(cache_MemWrite), 16'd0);
    chk("rmw_addr", cache_mem_addr, 16'h0000);
    tick();
    // Three words of the fill, then reset aborts it.
    for (int k = 0; k < 3; k++) begin
      MemDataValid  = 1'b1;
      mem_read_data = 16'hA000 + 16'(k);
      #1;
      chk("abort_mrd",  16'(cache_MemRead), 16'd1);
      chk("abort_addr", cache_mem_addr, 16'h3000 + 16'(2 * k));
      chk("abort_mwr",  16'(cache_MemWrite), 16'd0);
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_quiet("post_rst");
    pipe_MemRead   = 1'b1;
    pipe_read_addr = 16'h0004;
    #1;
    chk("rst_miss_hit",  16'(CacheHit), 16'd0);
    chk("rst_miss_busy", 16'(CacheBusy), 16'd1);
    pipe_read_addr = 16'h3000;
    #1;
    chk("rst_part_hit", 16'(CacheHit), 16'd0);
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
